// File: rtl/dsp_mac_pipe.sv
// Three-stage signed pre-add / multiply / post-add MAC with a per-sample valid bit and opmode.
// Optional saturation, overflow and zero flags; P feeds back for accumulation and drives PCOUT.
module dsp_mac_pipe #(
  parameter int A_WIDTH  = 18,
  parameter int B_WIDTH  = 18,
  parameter int C_WIDTH  = 48,
  parameter int P_WIDTH  = 48,
  parameter bit SATURATE = 1'b1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      CE,
  input  logic                      IN_VALID,
  input  logic signed [A_WIDTH-1:0] A,
  input  logic signed [B_WIDTH-1:0] B,
  input  logic signed [B_WIDTH-1:0] D,
  input  logic signed [C_WIDTH-1:0] C,
  input  logic signed [P_WIDTH-1:0] PCIN,
  input  logic [4:0]                OPMODE,
  output logic signed [P_WIDTH-1:0] P,
  output logic signed [P_WIDTH-1:0] PCOUT,
  output logic                      OUT_VALID,
  output logic                      OVF,
  output logic                      ZERO
);
  localparam int M_WIDTH = A_WIDTH + B_WIDTH + 1;
  localparam int S_WIDTH = P_WIDTH + 1;
  localparam logic [P_WIDTH-1:0] P_MAX = {1'b0, {(P_WIDTH-1){1'b1}}};
  localparam logic [P_WIDTH-1:0] P_MIN = {1'b1, {(P_WIDTH-1){1'b0}}};

  // Valid semantics: IN_VALID marks a sample (no backpressure, no ready); the valid bit travels
  // with its data and OUT_VALID pulses once when that sample's result lands in P. CE=0 freezes all.
  logic [A_WIDTH-1:0] a1_q, a1_d;
  logic [B_WIDTH-1:0] b1_q, b1_d, d1_q, d1_d;
  logic [C_WIDTH-1:0] c1_q, c1_d, c2_q, c2_d;
  logic [4:0]         op1_q, op1_d;
  logic               v1_q, v1_d, v2_q, v2_d;
  logic [M_WIDTH-1:0] m2_q, m2_d;
  logic [2:0]         op2_q, op2_d;
  logic [P_WIDTH-1:0] p_q, p_d;
  logic               ovf_q, ovf_d, zero_q, zero_d, out_valid_q, out_valid_d;

  logic [B_WIDTH:0]   b_ext, d_ext, pa;
  logic [M_WIDTH-1:0] a_ext, pa_ext;
  logic [S_WIDTH-1:0] x_ext, z_ext, s;
  logic [P_WIDTH-1:0] res;
  logic               ovf;

  always_comb begin
    a1_d  = A;
    b1_d  = B;
    d1_d  = D;
    c1_d  = C;
    op1_d = OPMODE;
    v1_d  = IN_VALID;
  end

  always_comb begin
    b_ext = {b1_q[B_WIDTH-1], b1_q};
    d_ext = {d1_q[B_WIDTH-1], d1_q};
    pa    = b_ext;
    if (op1_q[0]) begin
      pa = op1_q[1] ? (d_ext - b_ext) : (d_ext + b_ext);
    end
    // Both operands are widened to the full product width so the truncated product is exact.
    a_ext  = {{(M_WIDTH-A_WIDTH){a1_q[A_WIDTH-1]}}, a1_q};
    pa_ext = {{(M_WIDTH-B_WIDTH-1){pa[B_WIDTH]}}, pa};
    m2_d   = a_ext * pa_ext;
    c2_d   = c1_q;
    op2_d  = op1_q[4:2];
    v2_d   = v1_q;
  end

  always_comb begin
    x_ext = {{(S_WIDTH-M_WIDTH){m2_q[M_WIDTH-1]}}, m2_q};
    case (op2_q[1:0])
      2'd1:    z_ext = {{(S_WIDTH-C_WIDTH){c2_q[C_WIDTH-1]}}, c2_q};
      2'd2:    z_ext = {p_q[P_WIDTH-1], p_q};
      2'd3:    z_ext = {PCIN[P_WIDTH-1], PCIN};
      default: z_ext = '0;
    endcase
    s   = op2_q[2] ? (z_ext - x_ext) : (z_ext + x_ext);
    ovf = s[S_WIDTH-1] ^ s[S_WIDTH-2];
    res = s[P_WIDTH-1:0];
    if (SATURATE && ovf) begin
      res = s[S_WIDTH-1] ? P_MIN : P_MAX;
    end
    // Bubbles leave the result registers untouched so accumulation survives idle cycles.
    p_d         = v2_q ? res : p_q;
    ovf_d       = v2_q ? ovf : ovf_q;
    zero_d      = v2_q ? (res == '0) : zero_q;
    out_valid_d = v2_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      a1_q        <= '0;
      b1_q        <= '0;
      d1_q        <= '0;
      c1_q        <= '0;
      op1_q       <= '0;
      v1_q        <= 1'b0;
      m2_q        <= '0;
      c2_q        <= '0;
      op2_q       <= '0;
      v2_q        <= 1'b0;
      p_q         <= '0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (CE) begin
      a1_q        <= a1_d;
      b1_q        <= b1_d;
      d1_q        <= d1_d;
      c1_q        <= c1_d;
      op1_q       <= op1_d;
      v1_q        <= v1_d;
      m2_q        <= m2_d;
      c2_q        <= c2_d;
      op2_q       <= op2_d;
      v2_q        <= v2_d;
      p_q         <= p_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign P         = p_q;
  assign PCOUT     = p_q;
  assign OUT_VALID = out_valid_q;
  assign OVF       = ovf_q;
  assign ZERO      = zero_q;
endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Bench for dsp_mac_pipe: a saturating and a wrapping instance (P_WIDTH=37) share one stimulus.
// Drivers push expected results with their due enabled-edge count; a negedge monitor pops and compares.
module tb_dsp_mac_pipe;
  localparam int AW = 18;
  localparam int BW = 18;
  localparam int CW = 37;
  localparam int PW = 37;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst = 1'b1, ce = 1'b1, in_valid = 1'b0;
  logic signed [AW-1:0] a = '0;
  logic signed [BW-1:0] b = '0, d = '0;
  logic signed [CW-1:0] c = '0;
  logic signed [PW-1:0] pcin = '0;
  logic [4:0]           opmode = '0;

  logic [PW-1:0] p_s, pcout_s, p_w, pcout_w;
  logic          ov_s, ovf_s, zero_s, ov_w, ovf_w, zero_w;

  dsp_mac_pipe #(.A_WIDTH(AW), .B_WIDTH(BW), .C_WIDTH(CW), .P_WIDTH(PW), .SATURATE(1'b1)) u_sat (
    .CLK(clk), .RST(rst), .CE(ce), .IN_VALID(in_valid), .A(a), .B(b), .D(d), .C(c),
    .PCIN(pcin), .OPMODE(opmode), .P(p_s), .PCOUT(pcout_s), .OUT_VALID(ov_s),
    .OVF(ovf_s), .ZERO(zero_s));

  dsp_mac_pipe #(.A_WIDTH(AW), .B_WIDTH(BW), .C_WIDTH(CW), .P_WIDTH(PW), .SATURATE(1'b0)) u_wrap (
    .CLK(clk), .RST(rst), .CE(ce), .IN_VALID(in_valid), .A(a), .B(b), .D(d), .C(c),
    .PCIN(pcin), .OPMODE(opmode), .P(p_w), .PCOUT(pcout_w), .OUT_VALID(ov_w),
    .OVF(ovf_w), .ZERO(zero_w));

  typedef struct packed {
    logic [31:0]   due;
    logic [PW-1:0] p_s;
    logic          ovf_s;
    logic [PW-1:0] p_w;
    logic          ovf_w;
  } exp_t;

  exp_t exp_q[$];
  int   err_cnt = 0;
  int   chk_cnt = 0;
  int   ecyc = 0;
  logic last_en = 1'b0, last_rst = 1'b1;

  // ecyc counts edges that actually advance the pipeline.
  always @(posedge clk) begin
    last_rst <= rst;
    last_en  <= ce && !rst;
    if (ce && !rst) ecyc <= ecyc + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  logic          exp_ov = 1'b0;
  logic [PW+1:0] hold_s = {{PW{1'b0}}, 2'b01};
  logic [PW+1:0] hold_w = {{PW{1'b0}}, 2'b01};
  exp_t          mon_e;

  always @(negedge clk) begin
    if (last_rst) begin
      exp_ov = 1'b0;
      hold_s = {{PW{1'b0}}, 2'b01};
      hold_w = {{PW{1'b0}}, 2'b01};
    end else if (last_en) begin
      exp_ov = (exp_q.size() > 0) && (exp_q[0].due == ecyc);
      if (exp_ov) begin
        mon_e  = exp_q.pop_front();
        hold_s = {mon_e.p_s, mon_e.ovf_s, mon_e.p_s == '0};
        hold_w = {mon_e.p_w, mon_e.ovf_w, mon_e.p_w == '0};
      end
    end
    chk("out_valid_sat", 64'(ov_s), 64'(exp_ov));
    chk("out_valid_wrap", 64'(ov_w), 64'(exp_ov));
    chk("p_ovf_zero_sat", 64'({p_s, ovf_s, zero_s}), 64'(hold_s));
    chk("p_ovf_zero_wrap", 64'({p_w, ovf_w, zero_w}), 64'(hold_w));
    chk("pcout_sat", 64'(pcout_s), 64'(hold_s[PW+1:2]));
    chk("pcout_wrap", 64'(pcout_w), 64'(hold_w[PW+1:2]));
  end

  task automatic drive(input logic signed [AW-1:0] av, input logic signed [BW-1:0] bv,
                       input logic signed [BW-1:0] dv, input logic signed [CW-1:0] cv,
                       input logic [4:0] op, input logic ce_v);
    @(negedge clk);
    a = av; b = bv; d = dv; c = cv; opmode = op; in_valid = 1'b1; ce = ce_v;
  endtask

  task automatic issue(input logic signed [AW-1:0] av, input logic signed [BW-1:0] bv,
                       input logic signed [BW-1:0] dv, input logic signed [CW-1:0] cv,
                       input logic [4:0] op, input logic [PW-1:0] ps, input logic ovs,
                       input logic [PW-1:0] pw, input logic ovw, input logic ce_v);
    exp_t ent;
    drive(av, bv, dv, cv, op, ce_v);
    ent.due   = 32'(ecyc + 3);
    ent.p_s   = ps;
    ent.ovf_s = ovs;
    ent.p_w   = pw;
    ent.ovf_w = ovw;
    exp_q.push_back(ent);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0; ce = 1'b1;
      a = AW'($urandom); b = BW'($urandom); d = BW'($urandom);
      c = CW'($urandom); opmode = 5'($urandom);
    end
  endtask

  localparam logic signed [AW-1:0] MN = -18'sd131072;

  initial begin
    // Reset with random inputs and a random CE.
    repeat (2) begin
      @(negedge clk);
      ce = 1'($urandom_range(0, 1)); in_valid = 1'($urandom_range(0, 1));
      a = AW'($urandom); b = BW'($urandom); d = BW'($urandom); opmode = 5'($urandom);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; ce = 1'b1;
    idle(2);

    // Plain multiply and zero result.
    issue(18'sd3, -18'sd4, 18'sd0, 37'sd0, 5'b00000, -37'sd12, 1'b0, -37'sd12, 1'b0, 1'b1);
    idle(4);
    issue(18'sd0, 18'sd77, 18'sd0, 37'sd0, 5'b00000, 37'sd0, 1'b0, 37'sd0, 1'b0, 1'b1);
    idle(3);

    // Pre-adder, C and PCIN paths, back to back with per-sample opmodes.
    pcin = 37'sd1000;
    issue(18'sd5, 18'sd4, 18'sd10, 37'sd100, 5'b00111, 37'sd130, 1'b0, 37'sd130, 1'b0, 1'b1);
    issue(18'sd5, 18'sd4, 18'sd10, 37'sd100, 5'b10111, 37'sd70, 1'b0, 37'sd70, 1'b0, 1'b1);
    issue(18'sd7, -18'sd3, 18'sd0, 37'sd0, 5'b01100, 37'sd979, 1'b0, 37'sd979, 1'b0, 1'b1);
    issue(18'sd2, 18'sd3, 18'sd4, 37'sd0, 5'b01101, 37'sd1014, 1'b0, 37'sd1014, 1'b0, 1'b1);
    idle(4);

    // Accumulation with bubbles up to overflow.
    issue(MN, MN, 18'sd0, 37'sd0, 5'b00000, 37'h04_0000_0000, 1'b0, 37'h04_0000_0000, 1'b0, 1'b1);
    idle(2);
    issue(MN, MN, 18'sd0, 37'sd0, 5'b01000, 37'h08_0000_0000, 1'b0, 37'h08_0000_0000, 1'b0, 1'b1);
    idle(1);
    issue(MN, MN, 18'sd0, 37'sd0, 5'b01000, 37'h0C_0000_0000, 1'b0, 37'h0C_0000_0000, 1'b0, 1'b1);
    idle(3);
    issue(MN, MN, 18'sd0, 37'sd0, 5'b01000, 37'h0F_FFFF_FFFF, 1'b1, 37'h10_0000_0000, 1'b1, 1'b1);
    idle(4);

    // Back-to-back accumulation with a 4-cycle CE stall while the samples are in flight.
    issue(18'sd1000, 18'sd1000, 18'sd0, 37'sd0, 5'b00000, 37'sd1000000, 1'b0, 37'sd1000000, 1'b0, 1'b1);
    issue(-18'sd2, 18'sd3, 18'sd0, 37'sd0, 5'b01000, 37'sd999994, 1'b0, 37'sd999994, 1'b0, 1'b1);
    issue(18'sd5, 18'sd5, 18'sd0, 37'sd0, 5'b11000, 37'sd999969, 1'b0, 37'sd999969, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    @(negedge clk);
    ce = 1'b1;
    idle(6);

    // Reset one cycle after two valid samples: both are discarded.
    drive(18'sd11, 18'sd12, 18'sd0, 37'sd0, 5'b00000, 1'b1);
    drive(18'sd13, 18'sd14, 18'sd0, 37'sd0, 5'b00000, 1'b1);
    @(negedge clk);
    rst = 1'b1; ce = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    ce = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    idle(5);

    // Recovery after reset.
    issue(18'sd2, 18'sd2, 18'sd0, 37'sd0, 5'b00000, 37'sd4, 1'b0, 37'sd4, 1'b0, 1'b1);
    idle(2);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
